zxbus_epcs_port: RTL and testbench

//  ZX-BUS I/O front end for the EPCS serial-flash shifter. Synchronises Z80 I/O cycles into clk and

---
 rtl/zxbus_epcs_pkg.sv | 32 +++
 rtl/epcs_cmd_fifo.sv | 55 +++++
 rtl/zxbus_epcs_port.sv | 206 ++++++++++++++++++++
 tb/tb_zxbus_epcs_port.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zxbus_epcs_pkg.sv
// rtl/zxbus_epcs_pkg.sv - shared constants, status layout and dispatcher states for the EPCS port
//
// Purpose: default port addresses, serial byte window, command word width,
//          status bit positions, dispatcher state enum and a level saturation helper.
// Ports:   none (package).
package zxbus_epcs_pkg;

  localparam logic [7:0] PORT_CTRL_DEF   = 8'hE7;
  localparam logic [7:0] PORT_DATA_DEF   = 8'hEF;
  localparam int         FIFO_DEPTH_DEF  = 4;
  localparam int         BYTE_CYCLES_DEF = 48;

  // Command word: bit 8 = is_ctrl, bits 7:0 = payload byte
  localparam int CMD_W = 9;

  // Status byte layout: {busy_any, full, ovf, 2'b0, level[2:0]}
  localparam int ST_BUSY = 7;
  localparam int ST_FULL = 6;
  localparam int ST_OVF  = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STB  = 2'd1,
    S_BUSY = 2'd2
  } disp_state_t;

  // The status field is only three bits wide; deeper FIFOs report 7.
  function automatic logic [2:0] sat_level(input logic [31:0] n);
    return (n > 32'd7) ? 3'd7 : n[2:0];
  endfunction

endpackage

// File: rtl/epcs_cmd_fifo.sv
// rtl/epcs_cmd_fifo.sv - synchronous command FIFO with full/empty/level
//
// Purpose: small FIFO between the ZX-bus decoder and the dispatcher.
//          Pointers carry one extra wrap bit so full/empty fall out of a compare.
// Ports:   clk, rst_n (async active-low)
//          push, push_data  - write side; a push while full is accepted only if a pop happens too
//          pop, pop_data    - read side; pop_data shows the head entry combinationally
//          full, empty, level
module epcs_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  assign do_pop  = pop & ~empty;
  // A slot freed by a same-cycle pop can be reused immediately.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/zxbus_epcs_port.sv
// rtl/zxbus_epcs_port.sv - ZX-BUS I/O front end pacing host writes into the EPCS shifter
//
// Purpose: synchronises Z80 I/O cycles, decodes the ctrl/data ports, queues writes
//          and emits one strobe per entry with a full serial byte window after data bytes.
//          Optional macro ZXBUS_WAIT_EN: stall the Z80 with WAIT instead of dropping
//          writes that hit a full FIFO.
// Ports:   clk, rst_n                          - clock, async active-low reset
//          zx_a, zx_d_in, zx_d_out, zx_d_oe    - ZX address/data bus
//          zx_iorq_n, zx_rd_n, zx_wr_n, zx_m1_n - async Z80 strobes
//          zx_wait_n                           - WAIT request (tied 1 without the macro)
//          epcs_wdata, ectrl_stb, edata_stb     - to the shifter
//          epcs_rdata                          - shifter receive byte
module zxbus_epcs_port
  import zxbus_epcs_pkg::*;
#(
  parameter logic [7:0] PORT_CTRL   = PORT_CTRL_DEF,
  parameter logic [7:0] PORT_DATA   = PORT_DATA_DEF,
  parameter int         FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int         BYTE_CYCLES = BYTE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] zx_a,
  input  logic [7:0] zx_d_in,
  output logic [7:0] zx_d_out,
  output logic       zx_d_oe,
  input  logic       zx_iorq_n,
  input  logic       zx_rd_n,
  input  logic       zx_wr_n,
  input  logic       zx_m1_n,
  output logic       zx_wait_n,
  output logic [7:0] epcs_wdata,
  output logic       ectrl_stb,
  output logic       edata_stb,
  input  logic [7:0] epcs_rdata
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = (BYTE_CYCLES > 2) ? $clog2(BYTE_CYCLES) : 1;

  // ---------------- synchronisers ----------------
  logic [1:0] iorq_sr, rd_sr, wr_sr, m1_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iorq_sr <= 2'b11;
      rd_sr   <= 2'b11;
      wr_sr   <= 2'b11;
      m1_sr   <= 2'b11;
    end else begin
      iorq_sr <= {iorq_sr[0], zx_iorq_n};
      rd_sr   <= {rd_sr[0],   zx_rd_n};
      wr_sr   <= {wr_sr[0],   zx_wr_n};
      m1_sr   <= {m1_sr[0],   zx_m1_n};
    end
  end

  // M1 low together with IORQ is an interrupt acknowledge, not a port cycle.
  logic wr_q, rd_q, wr_q_d;
  assign wr_q = ~iorq_sr[1] & ~wr_sr[1] & m1_sr[1];
  assign rd_q = ~iorq_sr[1] & ~rd_sr[1] & m1_sr[1];

  // ---------------- decode ----------------
  logic             a_ctrl, a_data, a_hit;
  logic             wr_hit;
  logic [CMD_W-1:0] cmd_in;

  assign a_ctrl = (zx_a == PORT_CTRL);
  assign a_data = (zx_a == PORT_DATA);
  assign a_hit  = a_ctrl | a_data;
  // The bus has been stable for two clocks when the synced qualifier rises.
  assign wr_hit = wr_q & ~wr_q_d & a_hit;
  assign cmd_in = {a_ctrl, zx_d_in};

  // ---------------- FIFO ----------------
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CMD_W-1:0] fifo_din, fifo_dout;
  logic [LW-1:0]    fifo_level;
  logic             slot_ok;
  logic             ovf_set;

  assign slot_ok = ~fifo_full | fifo_pop;

  epcs_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (fifo_din),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

`ifdef ZXBUS_WAIT_EN
  logic             pend_q;
  logic [CMD_W-1:0] pend_cmd_q;

  // A pending write is retried every cycle; it is lost only if the host
  // abandons the bus cycle before a slot opens.
  assign fifo_push = pend_q ? slot_ok : (wr_hit & slot_ok);
  assign fifo_din  = pend_q ? pend_cmd_q : cmd_in;
  assign ovf_set   = pend_q & ~slot_ok & ~wr_q;
  assign zx_wait_n = ~pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= 1'b0;
      pend_cmd_q <= '0;
    end else if (pend_q) begin
      if (slot_ok || !wr_q) pend_q <= 1'b0;
    end else if (wr_hit && !slot_ok) begin
      pend_q     <= 1'b1;
      pend_cmd_q <= cmd_in;
    end
  end
`else
  assign fifo_push = wr_hit;
  assign fifo_din  = cmd_in;
  assign ovf_set   = wr_hit & ~slot_ok;
  assign zx_wait_n = 1'b1;
`endif

  // ---------------- overflow flag ----------------
  logic rd_ctrl, rd_ctrl_d, ovf_q;

  assign rd_ctrl = rd_q & a_ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q_d    <= 1'b0;
      rd_ctrl_d <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_q_d    <= wr_q;
      rd_ctrl_d <= rd_ctrl;
      // A new overflow wins over the clear from a status read ending.
      if (ovf_set)                  ovf_q <= 1'b1;
      else if (rd_ctrl_d && !rd_ctrl) ovf_q <= 1'b0;
    end
  end

  // ---------------- dispatcher FSM ----------------
  disp_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          cur_ctrl_q;
  logic          eng_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (!fifo_empty) state_d = S_STB;
      S_STB:  state_d = cur_ctrl_q ? S_IDLE : S_BUSY;
      S_BUSY: if (cnt_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_pop  = (state_q == S_IDLE) & ~fifo_empty;
    ectrl_stb = (state_q == S_STB) &  cur_ctrl_q;
    edata_stb = (state_q == S_STB) & ~cur_ctrl_q;
    eng_busy  = (state_q != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      cur_ctrl_q <= 1'b0;
      epcs_wdata <= 8'h00;
    end else begin
      if (fifo_pop) begin
        cur_ctrl_q <= fifo_dout[CMD_W-1];
        epcs_wdata <= fifo_dout[7:0];
      end
      if (state_q == S_STB)                 cnt_q <= CW'(BYTE_CYCLES - 1);
      else if (state_q == S_BUSY && cnt_q != '0) cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // ---------------- read mux ----------------
  logic [7:0] status;
  logic       rd_win;

  always_comb begin
    status          = 8'h00;
    status[ST_BUSY] = eng_busy | ~fifo_empty;
    status[ST_FULL] = fifo_full;
    status[ST_OVF]  = ovf_q;
    status[2:0]     = sat_level(32'(fifo_level));
  end

  assign rd_win   = rd_q & a_hit;
  assign zx_d_oe  = rd_win;
  assign zx_d_out = !rd_win ? 8'h00 : (a_data ? epcs_rdata : status);

endmodule

// File: tb/tb_zxbus_epcs_port.sv
// tb/tb_zxbus_epcs_port.sv - self-checking bench for the ZX-BUS EPCS port
`timescale 1ns/1ps
module tb_zxbus_epcs_port;

  localparam int         DEPTH  = 4;
  localparam int         BC     = 48;
  localparam logic [7:0] P_CTRL = 8'hE7;
  localparam logic [7:0] P_DATA = 8'hEF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] zx_a = 8'h00, zx_d_in = 8'h00, epcs_rdata = 8'h00;
  logic       zx_iorq_n = 1'b1, zx_rd_n = 1'b1, zx_wr_n = 1'b1, zx_m1_n = 1'b1;
  logic [7:0] zx_d_out, epcs_wdata;
  logic       zx_d_oe, zx_wait_n, ectrl_stb, edata_stb;

  zxbus_epcs_port dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .zx_a       (zx_a),
    .zx_d_in    (zx_d_in),
    .zx_d_out   (zx_d_out),
    .zx_d_oe    (zx_d_oe),
    .zx_iorq_n  (zx_iorq_n),
    .zx_rd_n    (zx_rd_n),
    .zx_wr_n    (zx_wr_n),
    .zx_m1_n    (zx_m1_n),
    .zx_wait_n  (zx_wait_n),
    .epcs_wdata (epcs_wdata),
    .ectrl_stb  (ectrl_stb),
    .edata_stb  (edata_stb),
    .epcs_rdata (epcs_rdata)
  );

  always #4 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int tb_cyc   = 0;

  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, tb_cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Entries wait in a queue; the engine is described only by when it is
  // next free: a ctrl entry occupies pop+strobe, a data entry also its byte window.
  bit [1:0]   m_iorq = 2'b11, m_rd = 2'b11, m_wr = 2'b11, m_m1 = 2'b11;
  bit         m_wrq_d = 0, m_stat_d = 0, m_ovf = 0, m_pend = 0, m_stb_ctrl = 0;
  logic [8:0] m_pend_cmd = '0;
  logic [8:0] m_q[$];
  int         m_cyc = 0, m_free_at = 0, m_stb_cyc = -1;
  logic [7:0] m_wdata = 8'h00;

  function automatic logic [7:0] m_status();
    int n;
    logic busy;
    logic [2:0] lv;
    n    = m_q.size();
    busy = (n > 0) || (m_cyc < m_free_at);
    lv   = (n > 7) ? 3'd7 : n[2:0];
    return {busy, (n == DEPTH), m_ovf, 2'b00, lv};
  endfunction

  always @(posedge clk) begin
    bit wrq, rdq, hit, stat_now, clr, pop, slot, set;
    logic [8:0] cmd, e;
    if (!rst_n) begin
      m_iorq = 2'b11; m_rd = 2'b11; m_wr = 2'b11; m_m1 = 2'b11;
      m_wrq_d = 0; m_stat_d = 0; m_ovf = 0; m_pend = 0; m_stb_ctrl = 0;
      m_q.delete();
      m_cyc = 0; m_free_at = 0; m_stb_cyc = -1; m_wdata = 8'h00;
    end else begin
      wrq      = !m_iorq[1] && !m_wr[1] && m_m1[1];
      rdq      = !m_iorq[1] && !m_rd[1] && m_m1[1];
      hit      = wrq && !m_wrq_d && (zx_a == P_CTRL || zx_a == P_DATA);
      cmd      = {zx_a == P_CTRL, zx_d_in};
      stat_now = rdq && (zx_a == P_CTRL);
      clr      = m_stat_d && !stat_now;
      pop      = (m_q.size() > 0) && (m_cyc >= m_free_at);
      slot     = (m_q.size() < DEPTH) || pop;
      set      = 0;
      if (pop) begin
        e          = m_q.pop_front();
        m_wdata    = e[7:0];
        m_stb_cyc  = m_cyc + 1;
        m_stb_ctrl = e[8];
        m_free_at  = m_cyc + (e[8] ? 2 : 2 + BC);
      end
`ifdef ZXBUS_WAIT_EN
      if (m_pend) begin
        if (slot) begin m_q.push_back(m_pend_cmd); m_pend = 0; end
        else if (!wrq) begin m_pend = 0; set = 1; end
      end else if (hit) begin
        if (slot) m_q.push_back(cmd);
        else begin m_pend = 1; m_pend_cmd = cmd; end
      end
`else
      if (hit) begin
        if (slot) m_q.push_back(cmd);
        else set = 1;
      end
`endif
      if (set) m_ovf = 1;
      else if (clr) m_ovf = 0;
      m_iorq   = {m_iorq[0], zx_iorq_n};
      m_rd     = {m_rd[0],   zx_rd_n};
      m_wr     = {m_wr[0],   zx_wr_n};
      m_m1     = {m_m1[0],   zx_m1_n};
      m_wrq_d  = wrq;
      m_stat_d = stat_now;
      m_cyc++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic rdq, win;
    logic [7:0] exp_out;
    #1;
    if (rst_n) begin
      rdq     = !m_iorq[1] && !m_rd[1] && m_m1[1];
      win     = rdq && (zx_a == P_CTRL || zx_a == P_DATA);
      exp_out = !win ? 8'h00 : ((zx_a == P_DATA) ? epcs_rdata : m_status());
      check("ectrl_stb", ectrl_stb, (m_cyc == m_stb_cyc) && m_stb_ctrl);
      check("edata_stb", edata_stb, (m_cyc == m_stb_cyc) && !m_stb_ctrl);
      check("epcs_wdata", epcs_wdata, m_wdata);
      check("zx_d_oe", zx_d_oe, win);
      check("zx_d_out", zx_d_out, exp_out);
`ifdef ZXBUS_WAIT_EN
      check("zx_wait_n", zx_wait_n, !m_pend);
`else
      check("zx_wait_n", zx_wait_n, 1);
`endif
    end
  end

  // ---------------- strobe log ----------------
  int         log_cyc[$];
  logic [7:0] log_dat[$];
  bit         log_ctl[$];

  always @(negedge clk) begin
    if (rst_n && (ectrl_stb || edata_stb)) begin
      log_cyc.push_back(tb_cyc);
      log_dat.push_back(epcs_wdata);
      log_ctl.push_back(ectrl_stb);
    end
  end

  task automatic clear_log();
    log_cyc.delete(); log_dat.delete(); log_ctl.delete();
  endtask

  // ---------------- bus tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic io_write(input logic [7:0] a, input logic [7:0] d, output int drv_cyc);
    int guard;
    @(negedge clk);
    zx_a = a; zx_d_in = d; zx_iorq_n = 1'b0; zx_wr_n = 1'b0;
    drv_cyc = tb_cyc;
    repeat (6) @(negedge clk);
    guard = 0;
    while (zx_wait_n == 1'b0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) check("wait_timeout", 1, 0);
    zx_iorq_n = 1'b1; zx_wr_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic io_read(input logic [7:0] a, output logic [7:0] v, output bit saw_oe);
    @(negedge clk);
    zx_a = a; zx_iorq_n = 1'b0; zx_rd_n = 1'b0;
    saw_oe = 0;
    v = 8'h00;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (zx_d_oe) saw_oe = 1;
      v = zx_d_out;
    end
    @(negedge clk);
    zx_iorq_n = 1'b1; zx_rd_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int d0;
    logic [7:0] v;
    bit saw;
    logic [7:0] burst [6];
    int exp_n;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ectrl", ectrl_stb, 0);
    check("rst_edata", edata_stb, 0);
    check("rst_wdata", epcs_wdata, 8'h00);
    check("rst_d_oe", zx_d_oe, 0);
    check("rst_d_out", zx_d_out, 8'h00);
    check("rst_wait_n", zx_wait_n, 1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // single ctrl write
    clear_log();
    io_write(P_CTRL, 8'h00, d0);
    idle(5);
    check("ctrl_count", log_cyc.size(), 1);
    if (log_cyc.size() == 1) begin
      check("ctrl_is_ctrl", log_ctl[0], 1);
      check("ctrl_data", log_dat[0], 8'h00);
      check("ctrl_latency", log_cyc[0] - d0, 4);
    end

    // three data bytes back-to-back
    clear_log();
    io_write(P_DATA, 8'h9F, d0);
    io_write(P_DATA, 8'h00, d0);
    io_write(P_DATA, 8'h00, d0);
    io_read(P_CTRL, v, saw);
    check("burst3_busy", v & 8'h80, 8'h80);
    idle(200);
    check("burst3_count", log_cyc.size(), 3);
    if (log_cyc.size() == 3) begin
      check("burst3_d0", log_dat[0], 8'h9F);
      check("burst3_d1", log_dat[1], 8'h00);
      check("burst3_d2", log_dat[2], 8'h00);
      check("burst3_gap0", log_cyc[1] - log_cyc[0], 50);
      check("burst3_gap1", log_cyc[2] - log_cyc[1], 50);
    end
    io_read(P_CTRL, v, saw);
    check("burst3_idle_status", v, 8'h00);

    // six data writes without gaps
    clear_log();
    burst = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    for (int i = 0; i < 6; i++) io_write(P_DATA, burst[i], d0);
    io_read(P_CTRL, v, saw);
`ifdef ZXBUS_WAIT_EN
    check("burst6_status", v & 8'hA0, 8'h80);
    exp_n = 6;
`else
    check("burst6_status", v & 8'hE0, 8'hA0);
    exp_n = 5;
`endif
    io_read(P_CTRL, v, saw);
    check("burst6_ovf_cleared", v & 8'h20, 8'h00);
    idle(400);
    check("burst6_count", log_cyc.size(), exp_n);
    for (int i = 0; i < exp_n && i < log_dat.size(); i++)
      check("burst6_data", log_dat[i], burst[i]);

    // ctrl queued behind a data byte
    clear_log();
    io_write(P_DATA, 8'h33, d0);
    io_write(P_CTRL, 8'h01, d0);
    idle(80);
    check("order_count", log_cyc.size(), 2);
    if (log_cyc.size() == 2) begin
      check("order_first_data", log_ctl[0], 0);
      check("order_second_ctrl", log_ctl[1], 1);
      check("order_ctrl_val", log_dat[1], 8'h01);
      check("order_gap", log_cyc[1] - log_cyc[0], 50);
    end

    // reads
    epcs_rdata = 8'h5A;
    io_read(P_DATA, v, saw);
    check("rdata_oe", saw, 1);
    check("rdata_val", v, 8'h5A);
    io_read(8'h1F, v, saw);
    check("foreign_oe", saw, 0);
    check("foreign_val", v, 8'h00);

    // reset in the middle of a byte window
    clear_log();
    io_write(P_DATA, 8'h77, d0);
    idle(15);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ectrl", ectrl_stb, 0);
    check("midrst_edata", edata_stb, 0);
    check("midrst_wdata", epcs_wdata, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    io_read(P_CTRL, v, saw);
    check("midrst_status", v, 8'h00);
    idle(80);
    check("midrst_no_stb", log_cyc.size(), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
